vec_fifo_group_reader: RTL and testbench

//  Read side of the vector FIFO array. Pops ARRAY_SIZE-wide signed vectors
//  (e.g. xyz vertices) from a show-ahead FIFO array and packs GROUP_SIZE

---
 rtl/fifo_pkg.sv | 15 +
 rtl/vec_fifo_group_reader.sv | 118 +++++++++++
 tb/tb_vec_fifo_group_reader.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared types for the vector FIFO array: one vector of signed components
// and the read-side state encoding.
package fifo_pkg;

   localparam int VEC_DATA_WIDTH = 32;
   localparam int VEC_ARRAY_SIZE = 3;

   typedef logic signed [VEC_ARRAY_SIZE-1:0][VEC_DATA_WIDTH-1:0] vec_t;

   typedef enum logic {
      FILL = 1'b0,
      HOLD = 1'b1
   } rd_state_t;

endpackage

// File: rtl/vec_fifo_group_reader.sv
// Pops vectors from a show-ahead FIFO array and packs GROUP_SIZE consecutive
// vectors into one beat on a valid/ready stream (slot 0 = oldest vector).
module vec_fifo_group_reader
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ARRAY_SIZE = 3,
   parameter int GROUP_SIZE = 3,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                                                clock,
   input  logic                                                reset,
   input  logic                                                fifo_empty,
   output logic                                                fifo_rd_en,
   input  logic [ARRAY_SIZE-1:0][DATA_WIDTH-1:0]               fifo_dout,
   input  logic                                                flush,
   output logic                                                out_valid,
   input  logic                                                out_ready,
   output logic [GROUP_SIZE-1:0][ARRAY_SIZE-1:0][DATA_WIDTH-1:0] out_data,
   output logic [CNT_WIDTH-1:0]                                out_count,
   output logic                                                busy
);

   // One spare bit keeps idx legal even when GROUP_SIZE==1.
   localparam int IDX_W = $clog2(GROUP_SIZE) + 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(GROUP_SIZE - 1);

   rd_state_t            state_q;
   logic [IDX_W-1:0]     idx_q;
   logic                 out_valid_q;
   logic [CNT_WIDTH-1:0] count_q;
   logic                 pop;
   logic                 xfer;

   assign xfer = out_valid_q && out_ready;
   assign pop  = !fifo_empty && reset && !flush &&
                 ((state_q == FILL) || ((state_q == HOLD) && out_ready));

   assign fifo_rd_en = pop;
   assign out_valid  = out_valid_q;
   assign out_count  = count_q;
   assign busy       = (state_q == FILL) && (idx_q != '0);

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q     <= FILL;
         idx_q       <= '0;
         out_valid_q <= 1'b0;
         count_q     <= '0;
      end else begin
         if (xfer) begin
            count_q <= count_q + CNT_WIDTH'(1);
         end
         if (flush) begin
            state_q     <= FILL;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
         end else begin
            case (state_q)
               FILL: begin
                  if (pop) begin
                     if (idx_q == LAST_IDX) begin
                        idx_q       <= '0;
                        state_q     <= HOLD;
                        out_valid_q <= 1'b1;
                     end else begin
                        idx_q <= idx_q + IDX_W'(1);
                     end
                  end
               end
               HOLD: begin
                  if (xfer) begin
                     if (pop && (GROUP_SIZE == 1)) begin
                        state_q <= HOLD;
                     end else if (pop) begin
                        idx_q       <= IDX_W'(1);
                        state_q     <= FILL;
                        out_valid_q <= 1'b0;
                     end else begin
                        idx_q       <= '0;
                        state_q     <= FILL;
                        out_valid_q <= 1'b0;
                     end
                  end
               end
               default: begin
                  state_q     <= FILL;
                  idx_q       <= '0;
                  out_valid_q <= 1'b0;
               end
            endcase
         end
      end
   end

   // Slot 0 also reloads on a pop in HOLD so the next group starts without a bubble.
   for (genvar gi = 0; gi < GROUP_SIZE; gi++) begin : g_slot
      logic                                 load;
      logic [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] slot_q;

      if (gi == 0) begin : g_first
         assign load = pop && ((state_q == HOLD) || (idx_q == '0));
      end else begin : g_rest
         assign load = pop && (state_q == FILL) && (idx_q == IDX_W'(gi));
      end

      always_ff @(posedge clock) begin
         if (!reset) begin
            slot_q <= '0;
         end else if (load) begin
            slot_q <= fifo_dout;
         end
      end

      assign out_data[gi] = slot_q;
   end

endmodule

// File: tb/tb_vec_fifo_group_reader.sv
// Bench for vec_fifo_group_reader: a default 3x3 instance and a GROUP_SIZE=1,
// CNT_WIDTH=4 instance, each fed by a show-ahead FIFO model.
module tb_vec_fifo_group_reader;
   import fifo_pkg::*;

   typedef logic [2:0][2:0][31:0] beat_t;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic        reset, flush, out_ready, fifo_empty, fifo_rd_en, out_valid, busy;
   vec_t        fifo_dout;
   beat_t       out_data;
   logic [15:0] out_count;

   logic                  b_flush, b_out_ready, b_fifo_empty, b_fifo_rd_en, b_out_valid, b_busy;
   vec_t                  b_fifo_dout;
   logic [0:0][2:0][31:0] b_out_data;
   logic [3:0]            b_out_count;

   vec_fifo_group_reader #(.DATA_WIDTH(32), .ARRAY_SIZE(3), .GROUP_SIZE(3), .CNT_WIDTH(16)) dut (
      .clock(clock), .reset(reset), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
      .fifo_dout(fifo_dout), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_count(out_count), .busy(busy)
   );

   vec_fifo_group_reader #(.DATA_WIDTH(32), .ARRAY_SIZE(3), .GROUP_SIZE(1), .CNT_WIDTH(4)) dut_b (
      .clock(clock), .reset(reset), .fifo_empty(b_fifo_empty), .fifo_rd_en(b_fifo_rd_en),
      .fifo_dout(b_fifo_dout), .flush(b_flush), .out_valid(b_out_valid), .out_ready(b_out_ready),
      .out_data(b_out_data), .out_count(b_out_count), .busy(b_busy)
   );

   // Show-ahead FIFO models: head visible while non-empty, popped on rd_en at posedge.
   vec_t       mem_a [0:255];
   vec_t       mem_b [0:255];
   logic [7:0] wr_a, rd_a, wr_b, rd_b;
   logic       gappy;
   logic       gap_ph = 1'b0;

   assign fifo_empty   = (rd_a == wr_a) || (gappy && gap_ph);
   assign fifo_dout    = mem_a[rd_a];
   assign b_fifo_empty = (rd_b == wr_b);
   assign b_fifo_dout  = mem_b[rd_b];

   int    cyc = 0;
   int    pop_cyc_a[$];
   int    pop_cyc_b[$];
   beat_t beats_a[$];
   int    beat_cyc_a[$];
   vec_t  beats_b[$];
   int    beat_cyc_b[$];
   int    viol_a = 0;
   int    viol_b = 0;

   always @(posedge clock) begin
      cyc <= cyc + 1;
      gap_ph <= gappy ? ~gap_ph : 1'b0;
      if (!reset) rd_a <= 8'd0;
      else if (fifo_rd_en) rd_a <= rd_a + 8'd1;
      if (!reset) rd_b <= 8'd0;
      else if (b_fifo_rd_en) rd_b <= rd_b + 8'd1;
      if (fifo_rd_en) pop_cyc_a.push_back(cyc);
      if (b_fifo_rd_en) pop_cyc_b.push_back(cyc);
      if (reset && out_valid && out_ready) begin
         beats_a.push_back(out_data);
         beat_cyc_a.push_back(cyc);
      end
      if (reset && b_out_valid && b_out_ready) begin
         beats_b.push_back(b_out_data[0]);
         beat_cyc_b.push_back(cyc);
      end
      if (fifo_rd_en && fifo_empty) viol_a <= viol_a + 1;
      if (b_fifo_rd_en && b_fifo_empty) viol_b <= viol_b + 1;
   end

   int checks = 0;
   int errors = 0;
   int exp_cnt_a = 0;
   int exp_cnt_b = 0;

   function automatic vec_t mk(int i);
      vec_t v;
      v[0] = 32'(i);
      v[1] = 32'(-i);
      v[2] = 32'(2 * i);
      return v;
   endfunction

   function automatic vec_t rnd_vec();
      vec_t v;
      for (int c = 0; c < 3; c++) begin
         case ($urandom_range(0, 3))
            0:       v[c] = 32'h8000_0000;
            1:       v[c] = 32'h7fff_ffff;
            default: v[c] = $urandom;
         endcase
      end
      return v;
   endfunction

   function automatic beat_t grp(vec_t a, vec_t b, vec_t c);
      beat_t r;
      r[0] = a;
      r[1] = b;
      r[2] = c;
      return r;
   endfunction

   task automatic push_a(vec_t v);
      mem_a[wr_a] = v;
      wr_a = wr_a + 8'd1;
   endtask

   task automatic push_b(vec_t v);
      mem_b[wr_b] = v;
      wr_b = wr_b + 8'd1;
   endtask

   task automatic test_reset();
      reset = 1'b0; flush = 1'b0; out_ready = 1'b0; gappy = 1'b0;
      b_flush = 1'b0; b_out_ready = 1'b0;
      wr_a = 8'd1; mem_a[0] = mk(99);
      wr_b = 8'd1; mem_b[0] = mk(98);
      for (int k = 0; k < 3; k++) begin
         @(negedge clock);
         checks++;
         if (fifo_rd_en !== 1'b0 || b_fifo_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_rd_en cycle %0d got %b/%b want 0/0", k, fifo_rd_en, b_fifo_rd_en);
         end
      end
      checks++;
      if (out_valid !== 1'b0 || out_count !== 16'd0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_state got valid=%b count=%0d busy=%b want 0 0 0", out_valid, out_count, busy);
      end
      checks++;
      if (out_data !== '0 || b_out_valid !== 1'b0 || b_out_count !== 4'd0 || b_busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_data got data=%h b_valid=%b b_count=%0d b_busy=%b want zeros", out_data, b_out_valid, b_out_count, b_busy);
      end
      @(negedge clock);
      reset = 1'b1; flush = 1'b1; b_flush = 1'b1;
      #1;
      checks++;
      if (fifo_rd_en !== 1'b0 || b_fifo_rd_en !== 1'b0) begin
         errors++;
         $display("FAIL flush_rd_en got %b/%b want 0/0", fifo_rd_en, b_fifo_rd_en);
      end
      @(negedge clock);
      checks++;
      if (pop_cyc_a.size() != 0 || pop_cyc_b.size() != 0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL flush_no_pop got pops=%0d/%0d valid=%b want 0/0 0", pop_cyc_a.size(), pop_cyc_b.size(), out_valid);
      end
      wr_a = rd_a; wr_b = rd_b;
      flush = 1'b0; b_flush = 1'b0;
   endtask

   task automatic test_streaming();
      int   p0 = pop_cyc_a.size();
      int   b0 = beats_a.size();
      vec_t v[6];
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         v[i] = mk(i + 1);
         push_a(v[i]);
      end
      for (int n = 0; n < 30 && beats_a.size() < b0 + 2; n++) @(negedge clock);
      repeat (2) @(negedge clock);
      exp_cnt_a += 2;
      checks++;
      if (pop_cyc_a.size() != p0 + 6 || pop_cyc_a[p0 + 5] - pop_cyc_a[p0] != 5) begin
         errors++;
         $display("FAIL stream_pops got %0d pops span %0d want 6 span 5", pop_cyc_a.size() - p0, pop_cyc_a[p0 + 5] - pop_cyc_a[p0]);
      end
      checks++;
      if (beats_a.size() != b0 + 2) begin
         errors++;
         $display("FAIL stream_beats got %0d want 2", beats_a.size() - b0);
      end
      for (int g = 0; g < 2; g++) begin
         checks++;
         if (beats_a[b0 + g] !== grp(v[3*g], v[3*g+1], v[3*g+2])) begin
            errors++;
            $display("FAIL stream_beat%0d got %h want %h", g, beats_a[b0 + g], grp(v[3*g], v[3*g+1], v[3*g+2]));
         end
      end
      checks++;
      if (out_count !== 16'(exp_cnt_a) || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL stream_count got %0d valid=%b want %0d 0", out_count, out_valid, 16'(exp_cnt_a));
      end
   endtask

   task automatic test_backpressure();
      int   p0 = pop_cyc_a.size();
      int   b0 = beats_a.size();
      vec_t v[6];
      out_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         v[i] = mk(i + 11);
         push_a(v[i]);
      end
      for (int k = 1; k <= 13; k++) begin
         @(negedge clock);
         if (k >= 3) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== grp(v[0], v[1], v[2])) begin
               errors++;
               $display("FAIL bp_hold cycle %0d got valid=%b data=%h want 1 %h", k, out_valid, out_data, grp(v[0], v[1], v[2]));
            end
         end
      end
      checks++;
      if (pop_cyc_a.size() != p0 + 3) begin
         errors++;
         $display("FAIL bp_pops got %0d want 3", pop_cyc_a.size() - p0);
      end
      out_ready = 1'b1;
      for (int n = 0; n < 20 && beats_a.size() < b0 + 2; n++) @(negedge clock);
      repeat (2) @(negedge clock);
      exp_cnt_a += 2;
      checks++;
      if (beat_cyc_a[b0] != pop_cyc_a[p0 + 3]) begin
         errors++;
         $display("FAIL bp_xfer_pop got xfer cyc %0d pop cyc %0d want equal", beat_cyc_a[b0], pop_cyc_a[p0 + 3]);
      end
      for (int g = 0; g < 2; g++) begin
         checks++;
         if (beats_a[b0 + g] !== grp(v[3*g], v[3*g+1], v[3*g+2])) begin
            errors++;
            $display("FAIL bp_beat%0d got %h want %h", g, beats_a[b0 + g], grp(v[3*g], v[3*g+1], v[3*g+2]));
         end
      end
      checks++;
      if (out_count !== 16'(exp_cnt_a)) begin
         errors++;
         $display("FAIL bp_count got %0d want %0d", out_count, 16'(exp_cnt_a));
      end
   endtask

   task automatic test_gappy();
      int   b0 = beats_a.size();
      vec_t v[9];
      gappy = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 9; i++) begin
         v[i] = rnd_vec();
         push_a(v[i]);
      end
      for (int n = 0; n < 80 && beats_a.size() < b0 + 3; n++) @(negedge clock);
      repeat (2) @(negedge clock);
      gappy = 1'b0;
      exp_cnt_a += 3;
      checks++;
      if (beats_a.size() != b0 + 3) begin
         errors++;
         $display("FAIL gappy_beats got %0d want 3", beats_a.size() - b0);
      end
      for (int g = 0; g < 3; g++) begin
         checks++;
         if (beats_a[b0 + g] !== grp(v[3*g], v[3*g+1], v[3*g+2])) begin
            errors++;
            $display("FAIL gappy_beat%0d got %h want %h", g, beats_a[b0 + g], grp(v[3*g], v[3*g+1], v[3*g+2]));
         end
      end
      checks++;
      if (out_count !== 16'(exp_cnt_a)) begin
         errors++;
         $display("FAIL gappy_count got %0d want %0d", out_count, 16'(exp_cnt_a));
      end
   endtask

   task automatic test_flush();
      int   p0 = pop_cyc_a.size();
      int   b0 = beats_a.size();
      vec_t v[5];
      vec_t w[6];
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) v[i] = rnd_vec();
      for (int i = 0; i < 6; i++) w[i] = rnd_vec();
      push_a(v[0]); push_a(v[1]);
      for (int n = 0; n < 10 && pop_cyc_a.size() < p0 + 2; n++) @(negedge clock);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL flush_busy_before got %b want 1", busy);
      end
      flush = 1'b1;
      push_a(v[2]); push_a(v[3]); push_a(v[4]);
      #1;
      checks++;
      if (fifo_rd_en !== 1'b0) begin
         errors++;
         $display("FAIL flush_fill_rd_en got %b want 0", fifo_rd_en);
      end
      @(negedge clock);
      checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0 || pop_cyc_a.size() != p0 + 2) begin
         errors++;
         $display("FAIL flush_fill got busy=%b valid=%b pops=%0d want 0 0 2", busy, out_valid, pop_cyc_a.size() - p0);
      end
      flush = 1'b0;
      for (int n = 0; n < 20 && beats_a.size() < b0 + 1; n++) @(negedge clock);
      repeat (2) @(negedge clock);
      exp_cnt_a += 1;
      checks++;
      if (beats_a[b0] !== grp(v[2], v[3], v[4])) begin
         errors++;
         $display("FAIL flush_fill_beat got %h want %h", beats_a[b0], grp(v[2], v[3], v[4]));
      end
      // Flush while holding a beat that is accepted in the same cycle.
      out_ready = 1'b0;
      push_a(w[0]); push_a(w[1]); push_a(w[2]);
      for (int n = 0; n < 10 && out_valid !== 1'b1; n++) @(negedge clock);
      p0 = pop_cyc_a.size();
      push_a(w[3]);
      flush = 1'b1;
      out_ready = 1'b1;
      #1;
      checks++;
      if (fifo_rd_en !== 1'b0) begin
         errors++;
         $display("FAIL flush_hold_rd_en got %b want 0", fifo_rd_en);
      end
      @(negedge clock);
      exp_cnt_a += 1;
      checks++;
      if (out_valid !== 1'b0 || out_count !== 16'(exp_cnt_a) || pop_cyc_a.size() != p0) begin
         errors++;
         $display("FAIL flush_hold got valid=%b count=%0d pops=%0d want 0 %0d 0", out_valid, out_count, pop_cyc_a.size() - p0, 16'(exp_cnt_a));
      end
      flush = 1'b0;
      push_a(w[4]); push_a(w[5]);
      for (int n = 0; n < 20 && beats_a.size() < b0 + 3; n++) @(negedge clock);
      repeat (2) @(negedge clock);
      exp_cnt_a += 1;
      checks++;
      if (beats_a[b0 + 1] !== grp(w[0], w[1], w[2]) || beats_a[b0 + 2] !== grp(w[3], w[4], w[5])) begin
         errors++;
         $display("FAIL flush_hold_beats got %h %h want %h %h", beats_a[b0 + 1], beats_a[b0 + 2], grp(w[0], w[1], w[2]), grp(w[3], w[4], w[5]));
      end
      checks++;
      if (out_count !== 16'(exp_cnt_a)) begin
         errors++;
         $display("FAIL flush_count got %0d want %0d", out_count, 16'(exp_cnt_a));
      end
   endtask

   task automatic test_random();
      for (int r = 0; r < 4; r++) begin
         int   b0 = beats_a.size();
         int   ng = $urandom_range(1, 4);
         vec_t v[$];
         for (int i = 0; i < 3 * ng; i++) begin
            v.push_back(rnd_vec());
            push_a(v[i]);
         end
         for (int n = 0; n < 300 && beats_a.size() < b0 + ng; n++) begin
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clock);
         end
         out_ready = 1'b1;
         repeat (2) @(negedge clock);
         exp_cnt_a += ng;
         checks++;
         if (beats_a.size() != b0 + ng) begin
            errors++;
            $display("FAIL rand%0d_beats got %0d want %0d", r, beats_a.size() - b0, ng);
         end
         for (int g = 0; g < ng; g++) begin
            checks++;
            if (beats_a[b0 + g] !== grp(v[3*g], v[3*g+1], v[3*g+2])) begin
               errors++;
               $display("FAIL rand%0d_beat%0d got %h want %h", r, g, beats_a[b0 + g], grp(v[3*g], v[3*g+1], v[3*g+2]));
            end
         end
         checks++;
         if (out_count !== 16'(exp_cnt_a)) begin
            errors++;
            $display("FAIL rand%0d_count got %0d want %0d", r, out_count, 16'(exp_cnt_a));
         end
      end
   endtask

   task automatic test_wrap_g1();
      int   b0 = beats_b.size();
      vec_t v[17];
      b_out_ready = 1'b1;
      for (int i = 0; i < 17; i++) begin
         v[i] = rnd_vec();
         v[i][i % 3] = 32'h8000_0000;
         push_b(v[i]);
      end
      for (int n = 0; n < 40 && beats_b.size() < b0 + 17; n++) @(negedge clock);
      repeat (2) @(negedge clock);
      exp_cnt_b += 17;
      checks++;
      if (beats_b.size() != b0 + 17 || beat_cyc_b[b0 + 16] - beat_cyc_b[b0] != 16) begin
         errors++;
         $display("FAIL g1_rate got %0d beats span %0d want 17 span 16", beats_b.size() - b0, beat_cyc_b[b0 + 16] - beat_cyc_b[b0]);
      end
      for (int i = 0; i < 17; i++) begin
         checks++;
         if (beats_b[b0 + i] !== v[i]) begin
            errors++;
            $display("FAIL g1_beat%0d got %h want %h", i, beats_b[b0 + i], v[i]);
         end
      end
      checks++;
      if (b_out_count !== 4'(exp_cnt_b) || b_out_valid !== 1'b0) begin
         errors++;
         $display("FAIL g1_wrap_count got %0d valid=%b want %0d 0", b_out_count, b_out_valid, 4'(exp_cnt_b));
      end
   endtask

   task automatic test_no_empty_pop();
      checks++;
      if (viol_a != 0 || viol_b != 0) begin
         errors++;
         $display("FAIL empty_pop got %0d/%0d want 0/0", viol_a, viol_b);
      end
   endtask

   initial begin
      wr_a = 8'd0;
      wr_b = 8'd0;
      test_reset();
      test_streaming();
      test_backpressure();
      test_gappy();
      test_flush();
      test_random();
      test_wrap_g1();
      test_no_empty_pop();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
